// File: rtl/depthwise_window_gen.sv
// Streams channel-planar pixels into 3x3 valid-padding windows for a depthwise stage.
// Optional build macro WINGEN_STRIDE2_EN emits only the stride-2 subset of windows.
module depthwise_window_gen #(
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32,
  parameter int CHANNELS = 3,
  parameter int DATA_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [9*DATA_W-1:0] win_data,
  output logic [1:0]          win_channel,
  output logic                frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {FILL, ACTIVE, DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [1:0]            ch;
  logic [DATA_W-1:0]     lb1 [IMG_W];
  logic [DATA_W-1:0]     lb2 [IMG_W];
  // Columns are packed {row r, row r-1, row r-2}; col_a is c-2, col_b is c-1.
  logic [3*DATA_W-1:0]   col_a, col_b, col_cur;
  logic [9*DATA_W-1:0]   win_nxt;
  logic                  accept, col_last, row_last, ch_last, emit;

  assign in_ready   = (!win_valid || win_ready) && (state != DONE);
  assign accept     = in_valid && in_ready;
  assign col_last   = (col == CW'(IMG_W - 1));
  assign row_last   = (row == RW'(IMG_H - 1));
  assign ch_last    = (ch == 2'(CHANNELS - 1));
  assign frame_done = (state == DONE);
  assign col_cur    = {in_data, lb1[col], lb2[col]};

`ifdef WINGEN_STRIDE2_EN
  assign emit = accept && (state == ACTIVE) && (col >= CW'(2)) && !row[0] && !col[0];
`else
  assign emit = accept && (state == ACTIVE) && (col >= CW'(2));
`endif

  // Byte k = (row k/3, col k%3) of the window, top-left at the LSB.
  assign win_nxt = {col_cur[2*DATA_W +: DATA_W], col_b[2*DATA_W +: DATA_W], col_a[2*DATA_W +: DATA_W],
                    col_cur[DATA_W +: DATA_W],   col_b[DATA_W +: DATA_W],   col_a[DATA_W +: DATA_W],
                    col_cur[0 +: DATA_W],        col_b[0 +: DATA_W],        col_a[0 +: DATA_W]};

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (accept && row == RW'(1) && col_last) state_nxt = ACTIVE;
      ACTIVE:  if (accept && row_last && col_last) state_nxt = ch_last ? DONE : FILL;
      DONE:    state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      col   <= '0;
      row   <= '0;
      ch    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (col_last) begin
          col <= '0;
          if (row_last) begin
            row <= '0;
            ch  <= ch_last ? 2'd0 : ch + 2'd1;
          end else begin
            row <= row + RW'(1);
          end
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  // Line buffers are not reset: rows 0 and 1 of every channel overwrite them before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[col] <= lb1[col];
      lb1[col] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_a       <= '0;
      col_b       <= '0;
      win_valid   <= 1'b0;
      win_data    <= '0;
      win_channel <= '0;
    end else begin
      if (accept) begin
        if (col_last) begin
          col_a <= '0;
          col_b <= '0;
        end else begin
          col_a <= col_b;
          col_b <= col_cur;
        end
      end
      if (emit) begin
        win_valid   <= 1'b1;
        win_data    <= win_nxt;
        win_channel <= ch;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_depthwise_window_gen.sv
// Directed bench for depthwise_window_gen with an ordered window scoreboard.
module tb_depthwise_window_gen;

  localparam int W     = 32;
  localparam int H     = 32;
  localparam int CH    = 3;
  localparam int FRAME = W * H * CH;
`ifdef WINGEN_STRIDE2_EN
  localparam int WPF = 225;
  localparam int STEP = 2;
`else
  localparam int WPF = 900;
  localparam int STEP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        win_valid;
  logic        win_ready;
  logic [71:0] win_data;
  logic [1:0]  win_channel;
  logic        frame_done;

  typedef struct {
    logic [71:0] dat;
    logic [1:0]  ch;
  } win_t;

  win_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   idx, nwin, fdc, mode, cyc;
  bit   exp_fd;

  localparam logic [71:0] FIRST_WIN = 72'h424140222120020100;

  depthwise_window_gen #(.IMG_W(W), .IMG_H(H), .CHANNELS(CH), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_channel(win_channel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int i);
    int f, j, c, r, p;
    f = i / FRAME;
    j = i % FRAME;
    p = j / (W * H);
    r = (j / W) % H;
    c = j % W;
    if (mode == 0) return 8'((p * 1024 + r * 32 + c) % 256);
    return 8'((f * 71 + p * 29 + r * 13 + c * 7 + r * c) % 256);
  endfunction

  task automatic build(input int nfr);
    win_t e;
    for (int f = 0; f < nfr; f++)
      for (int p = 0; p < CH; p++)
        for (int r = 2; r < H; r += STEP)
          for (int c = 2; c < W; c += STEP) begin
            for (int k = 0; k < 9; k++)
              e.dat[k*8 +: 8] = pix(f * FRAME + p * W * H + (r - 2 + k / 3) * W + (c - 2 + k % 3));
            e.ch = 2'(p);
            expq.push_back(e);
          end
  endtask

  task automatic reset_model(input int nfr);
    expq.delete();
    idx = 0; nwin = 0; fdc = 0; exp_fd = 1'b0;
    build(nfr);
  endtask

  task automatic do_reset(input int nfr);
    rst = 1'b1; in_valid = 1'b0; win_ready = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    reset_model(nfr);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic tick(input bit v, input bit wr);
    bit   acc;
    win_t e;
    chk("frame_done", {71'd0, frame_done}, {71'd0, exp_fd});
    if (frame_done) fdc++;
    in_valid = v; win_ready = wr; in_data = pix(idx);
    #1;
    if (wr) chk("in_ready", {71'd0, in_ready}, {71'd0, !exp_fd});
    acc = v && in_ready;
    if (win_valid && wr) begin
      nwin++;
      if (expq.size() == 0) chk("win_extra", 72'd1, 72'd0);
      else begin
        e = expq.pop_front();
        chk("win_data", win_data, e.dat);
        chk("win_channel", {70'd0, win_channel}, {70'd0, e.ch});
      end
    end
    exp_fd = acc && (idx % FRAME == FRAME - 1);
    if (acc) idx++;
    @(negedge clk);
  endtask

  initial begin
    mode = 0;
    do_reset(1);
    chk("rst_win_valid", {71'd0, win_valid}, 72'd0);
    chk("rst_win_data", win_data, 72'd0);
    chk("rst_win_channel", {70'd0, win_channel}, 72'd0);
    chk("rst_frame_done", {71'd0, frame_done}, 72'd0);
    chk("rst_in_ready", {71'd0, in_ready}, 72'd1);

    // First window appears only after the 67th pixel.
    repeat (66) tick(1'b1, 1'b1);
    chk("no_win_before_67", {71'd0, win_valid}, 72'd0);
    tick(1'b1, 1'b1);
    chk("first_win_valid", {71'd0, win_valid}, 72'd1);
    chk("first_win_data", win_data, FIRST_WIN);
    chk("first_win_channel", {70'd0, win_channel}, 72'd0);

    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0);
      chk("hold_valid", {71'd0, win_valid}, 72'd1);
      chk("hold_data", win_data, FIRST_WIN);
      chk("hold_in_ready", {71'd0, in_ready}, 72'd0);
    end

    cyc = 0;
    while (idx < FRAME && cyc < 10000) begin
      tick(1'b1, 1'b1);
      cyc++;
    end
    repeat (3) tick(1'b0, 1'b1);
    chk("frame_pixels", 72'(idx), 72'(FRAME));
    chk("frame_windows", 72'(nwin), 72'(WPF * CH));
    chk("frame_done_pulses", 72'(fdc), 72'd1);
    chk("frame_queue_empty", 72'(expq.size()), 72'd0);

    // Reset mid-frame with a window pending, then restart.
    do_reset(1);
    repeat (500) tick(1'b1, 1'b1);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_win_valid", {71'd0, win_valid}, 72'd0);
    chk("midrst_frame_done", {71'd0, frame_done}, 72'd0);
    reset_model(1);
    repeat (66) tick(1'b1, 1'b1);
    chk("midrst_no_early_win", {71'd0, win_valid}, 72'd0);
    tick(1'b1, 1'b1);
    chk("midrst_first_valid", {71'd0, win_valid}, 72'd1);
    chk("midrst_first_data", win_data, FIRST_WIN);
    chk("midrst_first_channel", {70'd0, win_channel}, 72'd0);

    // Three frames with random handshakes and non-ramp data.
    mode = 1;
    do_reset(3);
    cyc = 0;
    while (idx < 3 * FRAME && cyc < 60000) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      cyc++;
    end
    repeat (3) tick(1'b0, 1'b1);
    chk("rand_pixels", 72'(idx), 72'(3 * FRAME));
    chk("rand_windows", 72'(nwin), 72'(3 * WPF * CH));
    chk("rand_frame_done_pulses", 72'(fdc), 72'd3);
    chk("rand_queue_empty", 72'(expq.size()), 72'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
